ecdsa_pio_ctrl: RTL and testbench
=================================

// Module: ecdsa_pio_ctrl
// PURPOSE
//  PIO access sequencer for the ECDSA register slaves (ecdsa_reg and peers).
//  Accepts one host read/write at a time and decodes the slave select from the address.
//  Drives the slave strobes (reg_bs/reg_rd/reg_wr) and the shared clk_div tick.
//  Waits for the slave's ack (write) or rvalid (read) and returns the result to the host.
//  A timeout turns a missing slave response into an error completion.
// PARAMETERS
//  N_SLV      4     number of register slaves (1..8)
//  SEL_LSB    8     lsb of the slave-select field in host_addr; field width = clog2(N_SLV)
//  DIV_RATIO  4     clk_div period in clk cycles (>=2); clk_div is high 1 cycle per period
//  TMO_CYC    64    WAIT-state timeout in clk cycles (>=2*DIV_RATIO)
// PORTS
//  clk          in   1           system clock
//  resetn       in   1           asynchronous active-low reset
//  host_req     in   1           access request; qualified by host_ready
//  host_wr      in   1           1=write, 0=read; sampled with host_req
//  host_addr    in   PIO_NBITS   access address; sampled with host_req
//  host_wdata   in   PIO_NBITS   write data; sampled with host_req
//  host_ready   out  1           controller idle, can accept a request
//  host_done    out  1           1-cycle completion pulse
//  host_err     out  1           valid with host_done; 1=timeout or bad select
//  host_rdata   out  PIO_NBITS   read data; valid with host_done on a good read, else 0
//  clk_div      out  1           divided tick to all slaves
//  reg_bs       out  N_SLV       one-hot slave select
//  reg_rd       out  1           read strobe, 1 cycle
//  reg_wr       out  1           write strobe, 1 cycle
//  reg_addr     out  PIO_NBITS   latched host_addr
//  reg_din      out  PIO_NBITS   latched host_wdata
//  slv_ack      in   N_SLV       per-slave pio_ack
//  slv_rvalid   in   N_SLV       per-slave pio_rvalid
//  slv_rdata    in   N_SLV*PIO_NBITS  per-slave pio_rdata; slave i at [i*PIO_NBITS +: PIO_NBITS]
// BEHAVIOUR
//  Reset
//  - All outputs are 0, except host_ready, which is 1 (FSM in IDLE).
//  - div counter = 0; the first clk_div pulse comes DIV_RATIO cycles after reset release.
//  clk_div
//  - Free-running counter 0..DIV_RATIO-1; clk_div=1 when the counter equals DIV_RATIO-1.
//  - Independent of the FSM.
//  FSM: IDLE, ISSUE, WAIT, DONE
//  - IDLE: host_ready=1. On host_req, latch wr/addr/wdata and compute sel=addr[SEL_LSB +: clog2(N_SLV)].
//    If sel>=N_SLV, go to DONE with err=1 and no slave access. Otherwise go to ISSUE.
//  - ISSUE (1 cycle): reg_bs[sel]=1, and reg_wr=wr or reg_rd=~wr. Go to WAIT.
//  - WAIT: reg_bs[sel] is held, strobes are 0, and the timeout counter counts from 0.
//    Write completes on slv_ack[sel]=1. Read completes on slv_rvalid[sel]=1, capturing slv_rdata[sel].
//    On completion go to DONE with err=0.
//    If the counter reaches TMO_CYC-1 with no completion, go to DONE with err=1 and rdata=0.
//    Completion and timeout in the same cycle: completion wins.
//    Non-selected slave ack/rvalid are ignored.
//  - DONE (1 cycle): host_done=1, host_err and host_rdata valid, reg_bs=0. Next state is IDLE.
//  - Requests outside IDLE are ignored; the host must hold host_req until it sees host_ready.
//  Latency
//  - Accept at cycle T; strobe at T+1.
//  - If the response is sampled at cycle R, host_done is at R+1.
//  - Bad select: host_done at T+1.
//  Other rules
//  - reg_addr/reg_din stay stable from ISSUE through DONE and keep their value in IDLE.
//  - host_rdata is 0 on writes and on errors.
//  - Reset mid-access: reg_bs drops immediately and the FSM goes to IDLE; no host_done is produced.
// TESTING
//  1 Write addr=0x000 data=0x1234 to slave 0; slave acks on the next clk_div.
//    -> 1-cycle reg_wr, bs=0001 held, host_done with err=0, rdata=0.
//  2 Read slave 1 addr=0x100; slave returns rvalid with rdata=0xABCD.
//    -> 1-cycle reg_rd, host_done with host_rdata=0xABCD and err=0, exactly 1 cycle after rvalid.
//  3 Read slave 2 with no rvalid.
//    -> host_done at TMO_CYC+1 cycles after the strobe, err=1, rdata=0, bs released in DONE.
//  4 N_SLV=3, access addr=0x300.
//    -> no reg_bs/strobe, host_done at T+1 with err=1.
//  5 Ack on the timeout cycle; also unselected slv_ack pulses during WAIT.
//    -> err=0; the unselected acks have no effect.
//  6 Assert resetn=0 during WAIT, then release.
//    -> all outputs 0, host_ready=1, no host_done; clk_div restarts after DIV_RATIO cycles.

Source files
------------

// File: rtl/ecdsa_pio_ctrl_if.sv
// Host-side and register-bus-side interfaces of the ECDSA PIO access sequencer.
// The controller is the slave of the host interface and the master of the register bus.
interface ecdsa_pio_host_if #(
    parameter int PIO_NBITS = 16
);
    logic                 host_req;
    logic                 host_wr;
    logic [PIO_NBITS-1:0] host_addr;
    logic [PIO_NBITS-1:0] host_wdata;
    logic                 host_ready;
    logic                 host_done;
    logic                 host_err;
    logic [PIO_NBITS-1:0] host_rdata;

    modport master (
        output host_req, host_wr, host_addr, host_wdata,
        input  host_ready, host_done, host_err, host_rdata
    );

    modport slave (
        input  host_req, host_wr, host_addr, host_wdata,
        output host_ready, host_done, host_err, host_rdata
    );
endinterface

interface ecdsa_pio_reg_if #(
    parameter int N_SLV     = 4,
    parameter int PIO_NBITS = 16
);
    logic                       clk_div;
    logic [N_SLV-1:0]           reg_bs;
    logic                       reg_rd;
    logic                       reg_wr;
    logic [PIO_NBITS-1:0]       reg_addr;
    logic [PIO_NBITS-1:0]       reg_din;
    logic [N_SLV-1:0]           slv_ack;
    logic [N_SLV-1:0]           slv_rvalid;
    logic [N_SLV*PIO_NBITS-1:0] slv_rdata;

    modport master (
        output clk_div, reg_bs, reg_rd, reg_wr, reg_addr, reg_din,
        input  slv_ack, slv_rvalid, slv_rdata
    );

    modport slave (
        input  clk_div, reg_bs, reg_rd, reg_wr, reg_addr, reg_din,
        output slv_ack, slv_rvalid, slv_rdata
    );
endinterface

// File: rtl/ecdsa_pio_ctrl.sv
// PIO access sequencer: one host access at a time, decoded to a register slave,
// completed by the slave's ack/rvalid or by a WAIT timeout.
module ecdsa_pio_ctrl #(
    parameter int N_SLV     = 4,
    parameter int SEL_LSB   = 8,
    parameter int DIV_RATIO = 4,
    parameter int TMO_CYC   = 64,
    parameter int PIO_NBITS = 16
) (
    input logic             clk,
    input logic             resetn,
    ecdsa_pio_host_if.slave host,
    ecdsa_pio_reg_if.master pio
);
    localparam int SEL_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int DIV_W = $clog2(DIV_RATIO);
    localparam int TMO_W = $clog2(TMO_CYC);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic                 wr_q, wr_d;
    logic                 err_q, err_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [PIO_NBITS-1:0] addr_q, addr_d;
    logic [PIO_NBITS-1:0] din_q, din_d;
    logic [PIO_NBITS-1:0] rdata_q, rdata_d;

    logic [SEL_W-1:0]     req_sel;
    logic                 req_sel_ok;
    logic                 slv_hit;
    logic [PIO_NBITS-1:0] slv_sel_rdata;
    logic [N_SLV-1:0]     sel_onehot;

    // With a single slave there is no select field, so every access targets slave 0.
    assign req_sel       = (N_SLV == 1) ? '0 : host.host_addr[SEL_LSB +: SEL_W];
    assign req_sel_ok    = int'(req_sel) < N_SLV;
    assign slv_hit       = wr_q ? pio.slv_ack[sel_q] : pio.slv_rvalid[sel_q];
    assign slv_sel_rdata = pio.slv_rdata[int'(sel_q)*PIO_NBITS +: PIO_NBITS];

    always_comb begin
        sel_onehot        = '0;
        sel_onehot[sel_q] = 1'b1;
    end

    always_comb begin
        div_cnt_d = (div_cnt_q == DIV_W'(DIV_RATIO - 1)) ? '0 : div_cnt_q + 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        wr_d      = wr_q;
        err_d     = err_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        din_d     = din_q;
        rdata_d   = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (host.host_req) begin
                    wr_d      = host.host_wr;
                    addr_d    = host.host_addr;
                    din_d     = host.host_wdata;
                    rdata_d   = '0;
                    tmo_cnt_d = '0;
                    // A bad select completes immediately without touching any slave.
                    if (req_sel_ok) begin
                        sel_d   = req_sel;
                        err_d   = 1'b0;
                        state_d = S_ISSUE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // A response arriving on the timeout cycle still counts as a completion.
                if (slv_hit) begin
                    err_d   = 1'b0;
                    rdata_d = wr_q ? '0 : slv_sel_rdata;
                    state_d = S_DONE;
                end else if (tmo_cnt_q == TMO_W'(TMO_CYC - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            div_cnt_q <= '0;
            tmo_cnt_q <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            sel_q     <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            rdata_q   <= rdata_d;
        end
    end

    assign host.host_ready = (state_q == S_IDLE);
    assign host.host_done  = (state_q == S_DONE);
    assign host.host_err   = (state_q == S_DONE) && err_q;
    assign host.host_rdata = (state_q == S_DONE) ? rdata_q : '0;

    assign pio.clk_div  = (div_cnt_q == DIV_W'(DIV_RATIO - 1));
    assign pio.reg_bs   = ((state_q == S_ISSUE) || (state_q == S_WAIT)) ? sel_onehot : '0;
    assign pio.reg_rd   = (state_q == S_ISSUE) && !wr_q;
    assign pio.reg_wr   = (state_q == S_ISSUE) && wr_q;
    assign pio.reg_addr = addr_q;
    assign pio.reg_din  = din_q;
endmodule

// File: tb/tb_ecdsa_pio_ctrl.sv
// Directed bench for ecdsa_pio_ctrl: a transaction-level timing model is checked
// against every output on every cycle, plus hand-computed latency/data pins per vector.
module tb_ecdsa_pio_ctrl;
    localparam int N_SLV     = 3;
    localparam int SEL_LSB   = 8;
    localparam int DIV_RATIO = 4;
    localparam int TMO_CYC   = 16;
    localparam int NB        = 16;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    ecdsa_pio_host_if #(.PIO_NBITS(NB)) hif ();
    ecdsa_pio_reg_if #(.N_SLV(N_SLV), .PIO_NBITS(NB)) rif ();

    ecdsa_pio_ctrl #(
        .N_SLV    (N_SLV),
        .SEL_LSB  (SEL_LSB),
        .DIV_RATIO(DIV_RATIO),
        .TMO_CYC  (TMO_CYC),
        .PIO_NBITS(NB)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .host  (hif),
        .pio   (rif)
    );

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          d;          // response offset after the strobe cycle; -1 = next clk_div, 0 = none
        logic [15:0] rdata;
        bit          noise;      // unselected slaves pulse ack/rvalid early in WAIT
        int          rst_k;      // assert reset at this cycle of the access; 0 = never
        int          exp_lat;    // host_done cycle minus accept cycle; 0 = no done expected
        bit          exp_err;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [0:10];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model state, written by the stimulus as each access is issued.
    bit          in_reset = 1'b1;
    int          rel_cyc  = 0;
    bit          active   = 1'b0;
    int          acc_cyc  = -1;
    int          done_cyc = -1;
    bit          m_good, m_wr, m_err;
    int          m_sel;
    logic [15:0] m_rdata;
    logic [15:0] lat_addr = '0, old_addr = '0, lat_din = '0, old_din = '0;

    // Observations recorded by the compare process for the per-vector pins.
    int          obs_done_cyc   = -1;
    int          obs_strobe_cyc = -1;
    int          div_first      = -1;
    logic        obs_err;
    logic [15:0] obs_rdata;

    logic        e_ready, e_done, e_err, e_div, e_rd, e_wr;
    logic [15:0] e_rdata, e_addr, e_din;
    logic [2:0]  e_bs;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every output is predicted from the accept cycle and the response timing of the access.
    always @(negedge clk) begin
        if (in_reset) begin
            e_ready = 1'b1; e_done = 1'b0; e_err = 1'b0; e_rdata = '0; e_div = 1'b0;
            e_bs = '0; e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_din = '0;
        end else begin
            e_div   = ((cyc - rel_cyc) % DIV_RATIO) == DIV_RATIO - 1;
            e_ready = !(active && cyc > acc_cyc && cyc <= done_cyc);
            e_done  = active && cyc == done_cyc;
            e_err   = e_done && m_err;
            e_rdata = e_done ? m_rdata : '0;
            e_bs    = (active && m_good && cyc > acc_cyc && cyc < done_cyc) ? 3'(1 << m_sel) : '0;
            e_rd    = active && m_good && cyc == acc_cyc + 1 && !m_wr;
            e_wr    = active && m_good && cyc == acc_cyc + 1 && m_wr;
            e_addr  = (cyc > acc_cyc) ? lat_addr : old_addr;
            e_din   = (cyc > acc_cyc) ? lat_din : old_din;
        end
        checkOutput("host_ready", 64'(hif.host_ready), 64'(e_ready));
        checkOutput("host_done",  64'(hif.host_done),  64'(e_done));
        checkOutput("host_err",   64'(hif.host_err),   64'(e_err));
        checkOutput("host_rdata", 64'(hif.host_rdata), 64'(e_rdata));
        checkOutput("clk_div",    64'(rif.clk_div),    64'(e_div));
        checkOutput("reg_bs",     64'(rif.reg_bs),     64'(e_bs));
        checkOutput("reg_rd",     64'(rif.reg_rd),     64'(e_rd));
        checkOutput("reg_wr",     64'(rif.reg_wr),     64'(e_wr));
        checkOutput("reg_addr",   64'(rif.reg_addr),   64'(e_addr));
        checkOutput("reg_din",    64'(rif.reg_din),    64'(e_din));
        if (hif.host_done === 1'b1) begin
            obs_done_cyc = cyc;
            obs_err      = hif.host_err;
            obs_rdata    = hif.host_rdata;
        end
        if (rif.reg_rd === 1'b1 || rif.reg_wr === 1'b1) obs_strobe_cyc = cyc;
        if (rif.clk_div === 1'b1 && div_first < 0) div_first = cyc;
    end

    task automatic restoreSlaves();
        rif.slv_ack    = '0;
        rif.slv_rvalid = '0;
        for (int j = 0; j < N_SLV; j++) rif.slv_rdata[j*NB +: NB] = 16'hC000 + 16'(j);
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        int  t, s, d, sel, c;
        bit  good;
        obs_done_cyc   = -1;
        obs_strobe_cyc = -1;
        @(posedge clk);
        #2;
        t = cyc;
        s = t + 1;
        hif.host_req   = 1'b1;
        hif.host_wr    = v.wr;
        hif.host_addr  = v.addr;
        hif.host_wdata = v.wdata;
        sel  = (int'(v.addr) >> SEL_LSB) & 3;
        good = sel < N_SLV;
        d    = v.d;
        if (d < 0) begin
            d = 1;
            while (((s + d - rel_cyc) % DIV_RATIO) != DIV_RATIO - 1) d++;
        end
        old_addr = lat_addr; old_din = lat_din;
        lat_addr = v.addr;   lat_din = v.wdata;
        acc_cyc  = t; m_good = good; m_wr = v.wr; m_sel = sel; active = 1'b1;
        if (!good) begin
            done_cyc = t + 1; m_err = 1'b1; m_rdata = '0;
        end else if (d >= 1 && d <= TMO_CYC) begin
            done_cyc = s + d + 1; m_err = 1'b0; m_rdata = v.wr ? 16'h0 : v.rdata;
        end else begin
            done_cyc = s + TMO_CYC + 1; m_err = 1'b1; m_rdata = '0;
        end
        for (int k = 1; k <= TMO_CYC + 4; k++) begin
            @(posedge clk);
            #2;
            c = cyc;
            hif.host_req = 1'b0;
            restoreSlaves();
            if (good && d >= 1 && c == s + d) begin
                if (v.wr) rif.slv_ack[sel] = 1'b1;
                else begin
                    rif.slv_rvalid[sel]         = 1'b1;
                    rif.slv_rdata[sel*NB +: NB] = v.rdata;
                end
            end
            if (v.noise && c >= s + 1 && c <= s + 3) begin
                for (int j = 0; j < N_SLV; j++) begin
                    if (j != sel) begin
                        rif.slv_ack[j]    = 1'b1;
                        rif.slv_rvalid[j] = 1'b1;
                    end
                end
            end
            if (v.rst_k != 0 && k == v.rst_k) begin
                resetn = 1'b0; in_reset = 1'b1; active = 1'b0;
                lat_addr = '0; old_addr = '0; lat_din = '0; old_din = '0;
            end
            if (v.rst_k != 0 && k == v.rst_k + 3) begin
                resetn = 1'b1; in_reset = 1'b0; rel_cyc = c; div_first = -1;
            end
        end
        restoreSlaves();
        if (v.exp_lat > 0) begin
            checkOutput($sformatf("v%0d done_latency", idx), 64'(obs_done_cyc - t), 64'(v.exp_lat));
            checkOutput($sformatf("v%0d done_err", idx), 64'(obs_err), 64'(v.exp_err));
            checkOutput($sformatf("v%0d done_rdata", idx), 64'(obs_rdata), 64'(v.exp_rdata));
            if (good) checkOutput($sformatf("v%0d strobe_cycle", idx), 64'(obs_strobe_cyc - t), 64'(1));
            else      checkOutput($sformatf("v%0d no_strobe", idx), 64'(obs_strobe_cyc), 64'(-1));
        end else begin
            checkOutput($sformatf("v%0d no_done", idx), 64'(obs_done_cyc), 64'(-1));
        end
        if (v.rst_k != 0)
            checkOutput($sformatf("v%0d clk_div_restart", idx), 64'(div_first - rel_cyc), 64'(DIV_RATIO - 1));
    endtask

    initial begin
        resetn         = 1'b0;
        hif.host_req   = 1'b0;
        hif.host_wr    = 1'b0;
        hif.host_addr  = '0;
        hif.host_wdata = '0;
        restoreSlaves();
        //          wr    addr      wdata     d   rdata     nz    rst lat err   exp_rdata
        vecs[0]  = '{1'b1, 16'h0000, 16'h1234, -1, 16'h0000, 1'b0, 0, 3,  1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 16'h0100, 16'h0000, 3,  16'hABCD, 1'b0, 0, 5,  1'b0, 16'hABCD};
        vecs[2]  = '{1'b0, 16'h0200, 16'h0000, 0,  16'h0000, 1'b0, 0, 18, 1'b1, 16'h0000};
        vecs[3]  = '{1'b1, 16'h0300, 16'h5555, 0,  16'h0000, 1'b0, 0, 1,  1'b1, 16'h0000};
        vecs[4]  = '{1'b1, 16'h01A4, 16'hBEEF, 16, 16'h0000, 1'b1, 0, 18, 1'b0, 16'h0000};
        vecs[5]  = '{1'b0, 16'h00F0, 16'h0000, 1,  16'h0F0F, 1'b1, 0, 3,  1'b0, 16'h0F0F};
        vecs[6]  = '{1'b0, 16'h02C0, 16'h0000, 16, 16'h7E57, 1'b0, 0, 18, 1'b0, 16'h7E57};
        vecs[7]  = '{1'b1, 16'h02FF, 16'h00A5, 2,  16'h0000, 1'b0, 0, 4,  1'b0, 16'h0000};
        vecs[8]  = '{1'b0, 16'h03FF, 16'h0000, 0,  16'h0000, 1'b0, 0, 1,  1'b1, 16'h0000};
        vecs[9]  = '{1'b0, 16'h0210, 16'h0000, 0,  16'h0000, 1'b0, 5, 0,  1'b0, 16'h0000};
        vecs[10] = '{1'b0, 16'h0100, 16'h0000, 2,  16'h5A5A, 1'b1, 0, 4,  1'b0, 16'h5A5A};
        repeat (3) @(posedge clk);
        #2;
        resetn   = 1'b1;
        in_reset = 1'b0;
        rel_cyc  = cyc;
        $display("[TB] reset released at cycle %0d", rel_cyc);
        for (int i = 0; i <= 10; i++) applyStimulus(i, vecs[i]);
        repeat (2) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
